// File: rtl/zsw_press_classifier_if.sv
// ---------------------------------------------------------------------------
// zsw_press_classifier_if
// Bundles the debounced press/release pulses going into the press classifier
// and the gesture events coming out of it.
//   iSwDown  : one-cycle pulse on debounced press
//   iSwUp    : one-cycle pulse on debounced release
//   oShort   : one-cycle pulse, single short press classified
//   oLong    : one-cycle pulse, long-press threshold reached
//   oDouble  : one-cycle pulse, double click classified
//   oHeld    : level, high while the switch is held past the long threshold
//   oRepeat  : one-cycle auto-repeat pulse (0 unless auto-repeat is built in)
//   oEvtCnt  : running count of short/long/double pulses, wraps 255->0
//   oState   : classifier FSM state, for debug
// Modports: master = switch source / event consumer, slave = classifier.
// ---------------------------------------------------------------------------
interface zsw_press_classifier_if;
  logic       iSwDown;
  logic       iSwUp;
  logic       oShort;
  logic       oLong;
  logic       oDouble;
  logic       oHeld;
  logic       oRepeat;
  logic [7:0] oEvtCnt;
  logic [2:0] oState;

  modport master (
    output iSwDown, iSwUp,
    input  oShort, oLong, oDouble, oHeld, oRepeat, oEvtCnt, oState
  );

  modport slave (
    input  iSwDown, iSwUp,
    output oShort, oLong, oDouble, oHeld, oRepeat, oEvtCnt, oState
  );
endinterface

// File: rtl/zsw_press_classifier.sv
// ---------------------------------------------------------------------------
// zsw_press_classifier
// Classifies one switch's debounced press/release pulses into gesture events:
// short press, long press, double click and (optionally) auto-repeat.
// All outputs are registered; event pulses appear the cycle after the
// deciding input/timer condition is sampled.
// Ports:
//   iClk : fabric clock, rising edge
//   iRst : asynchronous active-high reset
//   bus  : zsw_press_classifier_if.slave (switch pulses in, events out)
// Optional feature: define ZSW_AUTOREPEAT_EN to emit oRepeat every
// REPEAT_CYC cycles while in LONG_HOLD. Without it oRepeat is tied 0 and the
// timer saturates in LONG_HOLD.
// ---------------------------------------------------------------------------
module zsw_press_classifier #(
  parameter int unsigned LONG_CYC    = 50000000,
  parameter int unsigned DBL_GAP_CYC = 15000000,
  parameter int unsigned REPEAT_CYC  = 10000000,
  parameter int unsigned CNT_W       = 26
) (
  input  logic                 iClk,
  input  logic                 iRst,
  zsw_press_classifier_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    WAIT_GAP  = 3'd2,
    PRESS2    = 3'd3,
    LONG_HOLD = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DBL_GAP_CYC - 1);
`ifdef ZSW_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);
`endif

  // Every threshold must be at least 2 and must fit in the timer.
  localparam bit CFG_OK = (LONG_CYC >= 2) && (DBL_GAP_CYC >= 2) && (REPEAT_CYC >= 2) &&
                          (64'(LONG_CYC)    <= (64'd1 << CNT_W)) &&
                          (64'(DBL_GAP_CYC) <= (64'd1 << CNT_W)) &&
                          (64'(REPEAT_CYC)  <= (64'd1 << CNT_W));

  generate
    if (!CFG_OK) begin : g_cfg_err
      $error("zsw_press_classifier: illegal LONG_CYC/DBL_GAP_CYC/REPEAT_CYC/CNT_W");
    end
  endgenerate

  state_t           state;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] timer_inc;
  logic             down_ok;
  logic             up_ok;
  logic             short_q;
  logic             long_q;
  logic             double_q;
  logic             held_q;
  logic             repeat_q;
  logic [7:0]       evt_cnt;

  // A press and release in the same cycle is treated as a glitch: both dropped.
  assign down_ok   = bus.iSwDown & ~bus.iSwUp;
  assign up_ok     = bus.iSwUp & ~bus.iSwDown;
  // Saturating increment so the timer never wraps.
  assign timer_inc = (&timer) ? timer : timer + CNT_W'(1);

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state    <= IDLE;
      timer    <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
      held_q   <= 1'b0;
      repeat_q <= 1'b0;
      evt_cnt  <= '0;
    end else begin
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
      repeat_q <= 1'b0;
      case (state)
        IDLE: begin
          timer <= '0;
          if (down_ok) state <= PRESS1;
        end
        PRESS1: begin
          // Release has priority over the long threshold in the same cycle.
          if (up_ok) begin
            state <= WAIT_GAP;
            timer <= '0;
          end else if (timer == LONG_LAST) begin
            state   <= LONG_HOLD;
            timer   <= '0;
            long_q  <= 1'b1;
            held_q  <= 1'b1;
            evt_cnt <= evt_cnt + 8'd1;
          end else begin
            timer <= timer_inc;
          end
        end
        WAIT_GAP: begin
          // A second press has priority over the gap timeout.
          if (down_ok) begin
            state <= PRESS2;
            timer <= '0;
          end else if (timer == GAP_LAST) begin
            state   <= IDLE;
            timer   <= '0;
            short_q <= 1'b1;
            evt_cnt <= evt_cnt + 8'd1;
          end else begin
            timer <= timer_inc;
          end
        end
        PRESS2: begin
          // A held second click still reports as a double, never as a long.
          if (up_ok) begin
            state    <= IDLE;
            timer    <= '0;
            double_q <= 1'b1;
            evt_cnt  <= evt_cnt + 8'd1;
          end else if (timer == LONG_LAST) begin
            state    <= LONG_HOLD;
            timer    <= '0;
            double_q <= 1'b1;
            held_q   <= 1'b1;
            evt_cnt  <= evt_cnt + 8'd1;
          end else begin
            timer <= timer_inc;
          end
        end
        LONG_HOLD: begin
          if (up_ok) begin
            state  <= IDLE;
            timer  <= '0;
            held_q <= 1'b0;
          end else begin
`ifdef ZSW_AUTOREPEAT_EN
            if (timer == REP_LAST) begin
              timer    <= '0;
              repeat_q <= 1'b1;
            end else begin
              timer <= timer_inc;
            end
`else
            timer <= timer_inc;
`endif
          end
        end
        default: begin
          state  <= IDLE;
          timer  <= '0;
          held_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.oShort  = short_q;
  assign bus.oLong   = long_q;
  assign bus.oDouble = double_q;
  assign bus.oHeld   = held_q;
  assign bus.oRepeat = repeat_q;
  assign bus.oEvtCnt = evt_cnt;
  assign bus.oState  = state;

endmodule
